// File: rtl/sfp_accum_pkg.sv
// Shared types and helpers for the sfp_accum post-array accumulator.
// Holds the job FSM state enum, the n_pass width and the saturating signed add.
package sfp_accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_t;

    localparam int NPASS_W = 4;
    localparam int SAT_W   = 32;

    typedef struct packed {
        logic                    sat;
        logic signed [SAT_W-1:0] val;
    } sat_res_t;

    // Operands are sign-extended to SAT_W; the sum is clamped to a bw-bit signed range.
    function automatic sat_res_t sat_add(input logic signed [SAT_W-1:0] a,
                                         input logic signed [SAT_W-1:0] b,
                                         input int bw);
        logic signed [SAT_W:0] sum;
        logic signed [SAT_W:0] max_v;
        logic signed [SAT_W:0] min_v;
        sat_res_t r;
        sum   = {a[SAT_W-1], a} + {b[SAT_W-1], b};
        max_v = {{SAT_W{1'b0}}, 1'b1};
        max_v = (max_v <<< (bw - 1)) - {{SAT_W{1'b0}}, 1'b1};
        min_v = -max_v - {{SAT_W{1'b0}}, 1'b1};
        r.sat = 1'b0;
        r.val = sum[SAT_W-1:0];
        if (sum > max_v) begin
            r.sat = 1'b1;
            r.val = max_v[SAT_W-1:0];
        end else if (sum < min_v) begin
            r.sat = 1'b1;
            r.val = min_v[SAT_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/sfp_accum_lane.sv
// sfp_lane: one saturating signed accumulator lane with sticky saturation flag.
// Optional build macro SFP_RELU_EN clamps the presented output at zero.
module sfp_lane
    import sfp_accum_pkg::*;
#(
    parameter int psum_bw = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr_i,
    input  logic               add_i,
    input  logic [psum_bw-1:0] din_i,
    output logic [psum_bw-1:0] dout_o,
    output logic               sat_o
);

    logic signed [psum_bw-1:0] acc_q, acc_d;
    logic                      sat_q, sat_d;
    logic signed [SAT_W-1:0]   acc_ext, din_ext;
    sat_res_t                  res;
    logic                      unused_hi;

    assign acc_ext   = SAT_W'(acc_q);
    assign din_ext   = SAT_W'($signed(din_i));
    assign res       = sat_add(acc_ext, din_ext, psum_bw);
    assign unused_hi = ^res.val[SAT_W-1:psum_bw];

    always_comb begin
        acc_d = acc_q;
        sat_d = sat_q;
        if (clr_i) begin
            acc_d = '0;
            sat_d = 1'b0;
        end else if (add_i) begin
            acc_d = res.val[psum_bw-1:0];
            sat_d = sat_q | res.sat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            sat_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            sat_q <= sat_d;
        end
    end

`ifdef SFP_RELU_EN
    assign dout_o = acc_q[psum_bw-1] ? '0 : acc_q;
`else
    assign dout_o = acc_q;
`endif
    assign sat_o = sat_q;

endmodule

// File: rtl/sfp_accum.sv
// sfp_accum: pops n_pass OFIFO rows, accumulates each lane with saturation, holds the result.
// Build macro SFP_RELU_EN (in sfp_lane) selects ReLU on out_data lanes.
//   state | meaning
//   IDLE  | waiting for start; start clears lanes and latches n_pass
//   ACCUM | popping rows whenever ofifo_valid, until n_pass rows taken
//   OUT   | result held on out_data until out_ready
module sfp_accum
    import sfp_accum_pkg::*;
#(
    parameter int psum_bw = 16,
    parameter int col     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [NPASS_W-1:0]     n_pass,
    input  logic                   ofifo_valid,
    input  logic [psum_bw*col-1:0] ofifo_rdata,
    output logic                   ofifo_rd,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [psum_bw*col-1:0] out_data,
    output logic                   busy,
    output logic [col-1:0]         sat
);

    state_t               state_q, state_d;
    logic [NPASS_W-1:0]   cnt_q, cnt_d;
    logic [NPASS_W-1:0]   npass_q, npass_d;
    logic                 clr;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        npass_d = npass_q;
        clr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    clr     = 1'b1;
                    cnt_d   = '0;
                    npass_d = (n_pass == '0) ? NPASS_W'(1) : n_pass;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (ofifo_valid) begin
                    cnt_d = cnt_q + NPASS_W'(1);
                    if (cnt_q + NPASS_W'(1) == npass_q) begin
                        state_d = OUT;
                    end
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            npass_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            npass_q <= npass_d;
        end
    end

    assign ofifo_rd  = (state_q == ACCUM) && ofifo_valid;
    assign out_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);

    for (genvar g = 0; g < col; g++) begin : g_lane
        sfp_lane #(
            .psum_bw(psum_bw)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .clr_i (clr),
            .add_i (ofifo_rd),
            .din_i (ofifo_rdata[g*psum_bw +: psum_bw]),
            .dout_o(out_data[g*psum_bw +: psum_bw]),
            .sat_o (sat[g])
        );
    end

endmodule

// File: tb/tb_sfp_accum.sv
// Self-checking bench for sfp_accum: directed scenarios plus randomized jobs
// checked against a plain-integer saturating-sum reference model.
module tb_sfp_accum;

    localparam int PW = 16;
    localparam int NC = 8;

    logic              clk = 1'b0;
    logic              reset, start, ofifo_valid, ofifo_rd, out_valid, out_ready, busy;
    logic [3:0]        n_pass;
    logic [PW*NC-1:0]  ofifo_rdata, out_data;
    logic [NC-1:0]     sat;

    int total = 0;
    int bad   = 0;

    int               rows [16][NC];
    int               vpat [$];
    bit               rand_valid;
    logic [PW*NC-1:0] exp_data;
    logic [NC-1:0]    exp_sat;
    int               pops, lat;
    bit               rd_ok;

    always #5 clk = ~clk;

    sfp_accum #(.psum_bw(PW), .col(NC)) dut (
        .clk(clk), .reset(reset), .start(start), .n_pass(n_pass),
        .ofifo_valid(ofifo_valid), .ofifo_rdata(ofifo_rdata), .ofifo_rd(ofifo_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .sat(sat)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: sum the first eff rows per lane, clamping after every add.
    task automatic model_job(input int eff);
        for (int l = 0; l < NC; l++) begin
            int s;
            bit f;
            s = 0;
            f = 1'b0;
            for (int r = 0; r < eff; r++) begin
                s = s + rows[r][l];
                if (s > 32767) begin s = 32767; f = 1'b1; end
                else if (s < -32768) begin s = -32768; f = 1'b1; end
            end
`ifdef SFP_RELU_EN
            if (s < 0) s = 0;
`endif
            exp_data[l*PW +: PW] = PW'(s);
            exp_sat[l] = f;
        end
    endtask

    task automatic load_row(input int p);
        int idx;
        idx = (p < 16) ? p : 15;
        for (int l = 0; l < NC; l++) ofifo_rdata[l*PW +: PW] = PW'(rows[idx][l]);
    endtask

    // Drives one job; reports pops seen, edges from start to out_valid, and ofifo_rd agreement.
    task automatic drive_job(input int np);
        int vi;
        bit v;
        start  = 1'b1;
        n_pass = 4'(np);
        ofifo_valid = 1'b0;
        tick();
        start = 1'b0;
        pops = 0; lat = 1; rd_ok = 1'b1; vi = 0;
        while (!out_valid && lat < 200) begin
            if (vpat.size() > 0) v = (vi < vpat.size()) ? (vpat[vi] != 0) : 1'b1;
            else if (rand_valid) v = 1'($urandom_range(0, 1));
            else v = 1'b1;
            vi++;
            ofifo_valid = v;
            load_row(pops);
            #1;
            if (ofifo_rd !== v) rd_ok = 1'b0;
            if (ofifo_rd === 1'b1) pops++;
            @(posedge clk);
            #1;
            lat++;
        end
        ofifo_valid = 1'b0;
    endtask

    task automatic transfer;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; ofifo_valid = 1'b1; out_ready = 1'b0;
        ofifo_rdata = {$urandom, $urandom, $urandom, $urandom};
        tick(); tick();
        total++; if (ofifo_rd !== 1'b0) begin bad++; $display("FAIL reset_rd got=%b want=0", ofifo_rd); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", out_data); end
        total++; if (sat !== '0) begin bad++; $display("FAIL reset_sat got=%b want=0", sat); end
        reset = 1'b0; ofifo_valid = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        for (int r = 0; r < 16; r++) for (int l = 0; l < NC; l++) rows[r][l] = 10;
        vpat.delete(); rand_valid = 1'b0;
        drive_job(3);
        total++; if (pops != 3) begin bad++; $display("FAIL basic_pops got=%0d want=3", pops); end
        total++; if (lat != 4) begin bad++; $display("FAIL basic_latency got=%0d want=4", lat); end
        total++; if (out_data !== {NC{16'd30}}) begin bad++; $display("FAIL basic_data got=%h want=%h", out_data, {NC{16'd30}}); end
        total++; if (sat !== '0) begin bad++; $display("FAIL basic_sat got=%b want=0", sat); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", busy); end
        transfer();
        total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL basic_xfer valid=%b busy=%b want 0 0", out_valid, busy); end
    endtask

    task automatic test_saturation;
        for (int r = 0; r < 2; r++) for (int l = 2; l < NC; l++) rows[r][l] = $urandom_range(0, 2000) - 1000;
        rows[0][0] = 32000;  rows[1][0] = 1000;
        rows[0][1] = -32000; rows[1][1] = -1000;
        vpat.delete(); rand_valid = 1'b0;
        drive_job(2);
        model_job(2);
        total++; if (out_data[15:0] !== 16'h7FFF) begin bad++; $display("FAIL sat_lane0 got=%h want=7fff", out_data[15:0]); end
`ifdef SFP_RELU_EN
        total++; if (out_data[31:16] !== 16'h0000) begin bad++; $display("FAIL sat_lane1 got=%h want=0000", out_data[31:16]); end
`else
        total++; if (out_data[31:16] !== 16'h8000) begin bad++; $display("FAIL sat_lane1 got=%h want=8000", out_data[31:16]); end
`endif
        total++; if (sat[1:0] !== 2'b11) begin bad++; $display("FAIL sat_flags got=%b want=11", sat[1:0]); end
        total++; if (out_data !== exp_data || sat !== exp_sat) begin bad++; $display("FAIL sat_model got=%h/%b want=%h/%b", out_data, sat, exp_data, exp_sat); end
        transfer();
    endtask

    task automatic test_valid_gaps;
        for (int r = 0; r < 16; r++) for (int l = 0; l < NC; l++) rows[r][l] = $urandom_range(0, 4000) - 2000;
        vpat = '{1, 0, 0, 1, 1}; rand_valid = 1'b0;
        drive_job(3);
        vpat.delete();
        model_job(3);
        total++; if (!rd_ok) begin bad++; $display("FAIL gaps_rd got=mismatch want=rd==valid"); end
        total++; if (pops != 3) begin bad++; $display("FAIL gaps_pops got=%0d want=3", pops); end
        total++; if (out_data !== exp_data) begin bad++; $display("FAIL gaps_data got=%h want=%h", out_data, exp_data); end
        transfer();
    endtask

    task automatic test_stall;
        for (int r = 0; r < 16; r++) for (int l = 0; l < NC; l++) rows[r][l] = $urandom_range(0, 60000) - 30000;
        vpat.delete(); rand_valid = 1'b0;
        drive_job(2);
        model_job(2);
        for (int c = 0; c < 5; c++) begin
            start = 1'b1; n_pass = 4'd5; ofifo_valid = 1'b1;
            #1;
            total++; if (ofifo_rd !== 1'b0) begin bad++; $display("FAIL stall_rd cycle=%0d got=%b want=0", c, ofifo_rd); end
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b1 || out_data !== exp_data || sat !== exp_sat) begin
                bad++; $display("FAIL stall_hold cycle=%0d got=%b/%h/%b want=1/%h/%b", c, out_valid, out_data, sat, exp_data, exp_sat);
            end
        end
        ofifo_valid = 1'b0;
        start = 1'b1; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL stall_start_on_xfer busy=%b valid=%b want 0 0", busy, out_valid); end
        tick();
        start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL start_after_xfer got=%b want=1", busy); end
        reset = 1'b1; tick(); reset = 1'b0;
    endtask

    task automatic test_reset_midjob;
        for (int r = 0; r < 4; r++) for (int l = 0; l < NC; l++) rows[r][l] = 20000;
        start = 1'b1; n_pass = 4'd4; tick(); start = 1'b0;
        for (int p = 0; p < 2; p++) begin
            ofifo_valid = 1'b1; load_row(p); tick();
        end
        reset = 1'b1; ofifo_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0 || busy !== 1'b0 || ofifo_rd !== 1'b0 || out_data !== '0 || sat !== '0) begin
            bad++; $display("FAIL midjob_reset got=%b/%b/%b/%h/%b want=0/0/0/0/0", out_valid, busy, ofifo_rd, out_data, sat);
        end
        reset = 1'b0;
        tick();
        for (int l = 0; l < NC; l++) rows[0][l] = 7;
        drive_job(1);
        model_job(1);
        total++; if (out_data !== exp_data || sat !== '0 || pops != 1) begin
            bad++; $display("FAIL midjob_newjob got=%h/%b/%0d want=%h/0/1", out_data, sat, pops, exp_data);
        end
        transfer();
    endtask

    task automatic test_npass_zero;
        for (int l = 0; l < NC; l++) rows[0][l] = -5;
        for (int l = 0; l < NC; l++) rows[1][l] = 100;
        drive_job(0);
        total++; if (pops != 1) begin bad++; $display("FAIL npass0_pops got=%0d want=1", pops); end
`ifdef SFP_RELU_EN
        total++; if (out_data !== '0) begin bad++; $display("FAIL npass0_data got=%h want=0", out_data); end
`else
        total++; if (out_data !== {NC{16'hFFFB}}) begin bad++; $display("FAIL npass0_data got=%h want=%h", out_data, {NC{16'hFFFB}}); end
`endif
        transfer();
    endtask

    task automatic test_back_to_back;
        vpat.delete(); rand_valid = 1'b1;
        for (int j = 0; j < 10; j++) begin
            int np, eff, span;
            np  = $urandom_range(0, 15);
            eff = (np == 0) ? 1 : np;
            span = (j % 2 == 0) ? 65535 : 8000;
            for (int r = 0; r < 16; r++) for (int l = 0; l < NC; l++) rows[r][l] = $urandom_range(0, span) - (span + 1) / 2;
            drive_job(np);
            model_job(eff);
            total++; if (pops != eff || !rd_ok) begin bad++; $display("FAIL rand_pops job=%0d got=%0d rd_ok=%0d want=%0d", j, pops, rd_ok, eff); end
            total++; if (out_valid !== 1'b1 || out_data !== exp_data || sat !== exp_sat) begin
                bad++; $display("FAIL rand_result job=%0d got=%b/%h/%b want=1/%h/%b", j, out_valid, out_data, sat, exp_data, exp_sat);
            end
            repeat ($urandom_range(0, 3)) tick();
            transfer();
        end
        rand_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; n_pass = '0; ofifo_valid = 1'b0; out_ready = 1'b0;
        ofifo_rdata = '0; rand_valid = 1'b0;
        test_reset();
        test_basic();
        test_saturation();
        test_valid_gaps();
        test_stall();
        test_reset_midjob();
        test_npass_zero();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sfp_accum.md
SFP_ACCUM -- requirements
Module: sfp_accum

Interface
REQ-001 Parameter psum_bw, default 16: per-column partial-sum width in bits.
REQ-002 Parameter col, default 8: number of columns (lanes).
REQ-003 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port start  input  1  pulse that begins one accumulation job; sampled only in IDLE.
REQ-006 Port n_pass  input  4  number of OFIFO rows to accumulate per job; sampled with start; 0 is treated as 1.
REQ-007 Port ofifo_valid  input  1  OFIFO has a row available on ofifo_rdata (show-ahead).
REQ-008 Port ofifo_rdata  input  psum_bw*col  row of signed psums; lane i is bits [psum_bw*(i+1)-1 : psum_bw*i].
REQ-009 Port ofifo_rd  output  1  pop strobe to OFIFO; a row is consumed on each clock edge where it is 1.
REQ-010 Port out_valid  output  1  result row is held on out_data.
REQ-011 Port out_ready  input  1  downstream accepts the result; the transfer occurs on an edge where out_valid and out_ready are both 1.
REQ-012 Port out_data  output  psum_bw*col  registered result row, same lane packing as ofifo_rdata.
REQ-013 Port busy  output  1  1 in every state other than IDLE.
REQ-014 Port sat  output  col  per-lane sticky saturation flag for the current job.

Function
REQ-015 The FSM SHALL have states IDLE, ACCUM and OUT; it leaves IDLE for ACCUM on start; it leaves ACCUM for OUT on the pop that completes n_pass rows; it leaves OUT for IDLE on the transfer edge.
REQ-016 On the start edge, the block SHALL clear the accumulators, sat and the pass counter, and latch n_pass (0 becomes 1).
REQ-017 ofifo_rd SHALL equal (state==ACCUM && ofifo_valid), combinationally, with no other qualifier.
REQ-018 Each pop SHALL add each lane of ofifo_rdata as a signed value to that lane's accumulator, with saturation to the signed psum_bw range (max 2^(psum_bw-1)-1, min -2^(psum_bw-1)).
REQ-019 A saturating lane SHALL set its sat bit; sat bits SHALL remain set until the next start or reset.
REQ-020 When ofifo_valid=0 in ACCUM, the FSM SHALL wait with the accumulators and counter unchanged; there is no timeout.
REQ-021 out_valid SHALL be 1 exactly while in OUT; it SHALL assert on the cycle after the final pop.
REQ-022 out_data SHALL hold the final accumulator values, post-processed per REQ-027, and SHALL be stable while out_valid=1 and out_ready=0.
REQ-023 start SHALL be ignored while busy=1.
REQ-024 A start on the same edge as the transfer out of OUT SHALL be ignored, because the block is not yet in IDLE; the earliest accepted start is one cycle later.
REQ-025 Minimum job latency SHALL be n_pass+1 cycles from the start edge to out_valid, when ofifo_valid is held at 1.

Reset
REQ-026 While reset=1, the block SHALL force state=IDLE, accumulators=0, counter=0, sat=0, out_valid=0, out_data=0, busy=0 and ofifo_rd=0; reset during ACCUM or OUT SHALL abandon the job with no result and pop no further rows.

Configuration
REQ-027 With macro SFP_RELU_EN defined, each out_data lane SHALL be max(acc,0); without it, out_data lanes SHALL be the raw saturated accumulators. sat behaviour is identical in both builds.

Structure
REQ-028 The shared package SHALL hold the FSM state enum (IDLE/ACCUM/OUT), the n_pass width constant (4) and the saturating signed-add function.
REQ-029 One sub-module, sfp_lane (a single-lane saturating accumulator plus optional ReLU), SHALL be instantiated col times.

Verification
REQ-030 psum_bw=16, col=8; start with n_pass=3; rows of all lanes=+10 with ofifo_valid held at 1 -> exactly 3 ofifo_rd pulses; out_valid 4 cycles after start; every lane=30; sat=0.
REQ-031 Lane 0 rows 32000 and 1000 (n_pass=2) -> lane 0 output=32767 and sat[0]=1; lane 1 rows -32000 and -1000 -> lane 1 output=-32768 without SFP_RELU_EN, 0 with it.
REQ-032 ofifo_valid toggled 1,0,0,1,1 with n_pass=3 -> ofifo_rd asserts only in valid cycles; result is the sum of exactly 3 rows.
REQ-033 out_ready held at 0 for 5 cycles in OUT -> out_data and out_valid stable; start pulses are ignored; no pops occur.
REQ-034 reset asserted after 2 of 4 pops -> all outputs 0 the next cycle; a new job with n_pass=1 and row=7 yields 7, with no carry-over from the abandoned job.
REQ-035 start with n_pass=0 and row=-5 -> one pop; output=-5 without SFP_RELU_EN, 0 with it.
